// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_port_arbiter
//  Description : Shares one SDRAM Avalon-MM master between two requesters
//                (port 0: notch filter write-back, port 1: Nios DMA/readback).
//                Round-robin, one transaction per grant. Read returns are
//                routed back through an owner-tag FIFO so pipelined reads from
//                both ports may be outstanding together.
//  Ports       : clk, reset_n (async, active low)
//                m0_* / m1_*  : requester-side Avalon-MM slave ports
//                sd_*         : SDRAM-controller-side Avalon-MM master port
//                err_orphan   : sticky, read data returned with no read pending
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_port_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] sd_address,
  output logic              sd_read,
  output logic              sd_write,
  output logic [DATA_W-1:0] sd_writedata,
  input  logic              sd_waitrequest,
  input  logic [DATA_W-1:0] sd_readdata,
  input  logic              sd_readdatavalid,
  output logic              err_orphan
);

  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_grant, last_grant_next;

  // Owner-tag FIFO: one bit per outstanding read, 0 = port 0, 1 = port 1.
  logic [MAX_PENDING-1:0] tag_mem;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   fifo_full, fifo_empty, head_tag;
  logic                   push, push_ok, push_tag, pop;
  logic                   elig0, elig1;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign head_tag   = tag_mem[rd_ptr];

  // Read dominates when read and write are both asserted, so a read+write
  // request is held off by a full FIFO exactly like a plain read.
  assign elig0 = m0_read ? !fifo_full : m0_write;
  assign elig1 = m1_read ? !fifo_full : m1_write;

  // Returns are in order, so the FIFO head always names the owner.
  assign pop              = sd_readdatavalid & !fifo_empty;
  assign m0_readdata      = sd_readdata;
  assign m1_readdata      = sd_readdata;
  assign m0_readdatavalid = pop & (head_tag == 1'b0);
  assign m1_readdatavalid = pop & (head_tag == 1'b1);

  // A simultaneous pop frees the slot the push needs, even when full.
  assign push_ok = push & (!fifo_full | pop);

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    sd_address      = '0;
    sd_read         = 1'b0;
    sd_write        = 1'b0;
    sd_writedata    = '0;
    m0_waitrequest  = 1'b1;
    m1_waitrequest  = 1'b1;
    push            = 1'b0;
    push_tag        = 1'b0;
    case (state)
      IDLE: begin
        // Port 0 wins a tie only if port 1 held the previous grant.
        if (elig0 && (!elig1 || last_grant)) begin
          state_next = OWN0;
        end else if (elig1) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        sd_address   = m0_address;
        sd_writedata = m0_writedata;
        sd_read      = m0_read;
        sd_write     = m0_write & ~m0_read;
        if (m0_read | m0_write) begin
          m0_waitrequest = sd_waitrequest;
          if (!sd_waitrequest) begin
            state_next      = IDLE;
            last_grant_next = 1'b0;
            push            = m0_read;
            push_tag        = 1'b0;
          end
        end else begin
          // Requester dropped its request while owning the bus.
          state_next = IDLE;
        end
      end
      OWN1: begin
        sd_address   = m1_address;
        sd_writedata = m1_writedata;
        sd_read      = m1_read;
        sd_write     = m1_write & ~m1_read;
        if (m1_read | m1_write) begin
          m1_waitrequest = sd_waitrequest;
          if (!sd_waitrequest) begin
            state_next      = IDLE;
            last_grant_next = 1'b1;
            push            = m1_read;
            push_tag        = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      tag_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      if (push_ok) begin
        tag_mem[wr_ptr] <= push_tag;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (sd_readdatavalid && fifo_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_port_arbiter
//  Description : Self-checking bench for sdram_port_arbiter. Two requester
//                drivers, an in-order SDRAM slave model, and a scoreboard
//                monitor that checks commands, read routing and err_orphan.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int MAX_PENDING = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic [ADDR_W-1:0] sd_address;
  logic sd_read, sd_write, err_orphan;
  logic [DATA_W-1:0] sd_writedata;
  logic force_wait = 1'b0, rnd_wait = 1'b0;
  logic sd_waitrequest;
  logic [DATA_W-1:0] sd_readdata = '0;
  logic sd_readdatavalid = 1'b0;

  assign sd_waitrequest = force_wait | rnd_wait;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sd_address(sd_address), .sd_read(sd_read), .sd_write(sd_write),
    .sd_writedata(sd_writedata), .sd_waitrequest(sd_waitrequest),
    .sd_readdata(sd_readdata), .sd_readdatavalid(sd_readdatavalid),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  // Contents of SDRAM as seen by reads: a fixed injective function of address.
  function automatic logic [31:0] mem_f(logic [23:0] a);
    return {8'h5A, a} ^ {a[7:0], 24'h1337C0};
  endfunction

  // ---------------- reference model / scoreboard state -----------------
  typedef struct { int owner; logic [31:0] data; } rd_exp_t;
  rd_exp_t exp_q[$];            // accepted reads, in issue order
  bit      exp_orphan = 0;
  int      lg = 1;              // last port granted
  int      lc = 0;              // cycle of last accept
  int      acc_port_q[$];
  int      acc_cyc_q[$];
  int      v0_cnt = 0, v1_cnt = 0;

  logic [23:0] req_addr[2];
  logic [31:0] req_wdata[2];
  bit          req_rd[2];
  int          req_start[2];

  // ---------------- SDRAM slave model ----------------------------------
  typedef struct { int due; logic [31:0] data; } ret_t;
  ret_t ret_q[$];
  int   lat_min = 1, lat_max = 1;
  bit   hold_returns = 0;
  bit   rnd_wait_en = 0;
  int   orphan_req = 0, orphan_ack = 0;

  always @(negedge clk) begin
    if (reset_n && sd_read && !sd_waitrequest)
      ret_q.push_back('{cyc + $urandom_range(lat_min, lat_max), mem_f(sd_address)});
  end

  always @(posedge clk) begin
    ret_t r;
    #1;
    sd_readdatavalid = 1'b0;
    sd_readdata = $urandom;
    if (orphan_req != orphan_ack) begin
      sd_readdatavalid = 1'b1;
      orphan_ack = orphan_req;
    end else if (!hold_returns && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      r = ret_q.pop_front();
      sd_readdatavalid = 1'b1;
      sd_readdata = r.data;
    end
    rnd_wait = rnd_wait_en && ($urandom_range(0, 99) < 30);
  end

  // ---------------- monitor ---------------------------------------------
  always @(negedge clk) begin
    bit a0, a1, jw, starved;
    int k, j;
    rd_exp_t e;
    if (!reset_n) begin
      exp_orphan = 0;
      exp_q.delete();
      lg = 1;
      lc = cyc;
    end else begin
      chk("err_orphan", err_orphan, exp_orphan);
      // Returns are handled before accepts: a same-cycle return belongs to an older read.
      if (sd_readdatavalid) begin
        if (exp_q.size() == 0) begin
          chk("orphan_no_valid", {m0_readdatavalid, m1_readdatavalid}, 0);
          exp_orphan = 1;
        end else begin
          e = exp_q.pop_front();
          chk("rd_route", {m0_readdatavalid, m1_readdatavalid}, (e.owner == 1) ? 2'b01 : 2'b10);
          chk("rd_data", (e.owner == 1) ? m1_readdata : m0_readdata, e.data);
          if (e.owner == 1) v1_cnt++; else v0_cnt++;
        end
      end else begin
        chk("stray_valid", {m0_readdatavalid, m1_readdatavalid}, 0);
      end
      a0 = (m0_read | m0_write) && !m0_waitrequest;
      a1 = (m1_read | m1_write) && !m1_waitrequest;
      if (a0 || a1) begin
        chk("single_grant", {a0, a1} == 2'b11, 0);
        k = a1 ? 1 : 0;
        j = 1 - k;
        chk("sd_cmd", {sd_read, sd_write, sd_address}, {req_rd[k], !req_rd[k], req_addr[k]});
        if (!req_rd[k]) chk("sd_wdata", sd_writedata, req_wdata[k]);
        chk("other_wait", (k == 1) ? m0_waitrequest : m1_waitrequest, 1);
        // A write on the other port pending since the last accept must win now.
        jw = (j == 1) ? (m1_write && !m1_read) : (m0_write && !m0_read);
        starved = (k == lg) && jw && (req_start[j] <= lc);
        chk("fair_grant", starved, 0);
        lg = k;
        lc = cyc;
        if (req_rd[k]) exp_q.push_back('{k, mem_f(req_addr[k])});
        acc_port_q.push_back(k);
        acc_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- requester drivers -----------------------------------
  task automatic drive(input int p, input logic rd, input logic wr,
                       input logic [23:0] a, input logic [31:0] d);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d;
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic issue(input int p, input logic rd, input logic [23:0] a,
                       input logic [31:0] d, input int budget, output bit ok);
    req_addr[p] = a; req_wdata[p] = d; req_rd[p] = rd; req_start[p] = cyc;
    drive(p, rd, !rd, a, d);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = reset_n && ((p == 0) ? !m0_waitrequest : !m1_waitrequest);
      @(posedge clk); #1;
    end
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && (exp_q.size() > 0 || ret_q.size() > 0); i++) begin
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  bit ok, ok5, ok9, okr, done9;
  int s, n;

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge clk); #1;
    chk("rst_sd_rw", {sd_read, sd_write}, 0);
    chk("rst_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
    chk("rst_valid", {m0_readdatavalid, m1_readdatavalid}, 0);
    chk("rst_orphan", err_orphan, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // ---- continuous writes from both ports alternate 0,1,0,1 ----
    acc_port_q.delete(); acc_cyc_q.delete();
    fork
      for (int i = 0; i < 4; i++) begin
        issue(0, 1'b0, 24'h000100 + 24'(i), 32'hA000_0000 + i, 50, ok); chk("alt_ok0", ok, 1);
      end
      for (int i = 0; i < 4; i++) begin
        issue(1, 1'b0, 24'h000200 + 24'(i), 32'hB000_0000 + i, 50, ok5); chk("alt_ok1", ok5, 1);
      end
    join
    chk("alt_count", acc_port_q.size(), 8);
    for (int i = 0; i < acc_port_q.size(); i++) begin
      chk("alt_order", acc_port_q[i], i % 2);
      if (i > 0) chk("alt_spacing", acc_cyc_q[i] - acc_cyc_q[i-1], 2);
    end

    // ---- reads from both ports, fixed latency 5, routed to owners ----
    lat_min = 5; lat_max = 5; v0_cnt = 0; v1_cnt = 0;
    fork
      begin issue(0, 1'b1, 24'h000010, 32'h0, 50, ok); chk("rd_ok0", ok, 1); end
      begin issue(1, 1'b1, 24'h000020, 32'h0, 50, ok5); chk("rd_ok1", ok5, 1); end
    join
    drain("rd_drain");
    chk("rd_valid_counts", {v0_cnt[7:0], v1_cnt[7:0]}, 16'h0101);

    // ---- tag FIFO full stalls reads, not writes ----
    hold_returns = 1; lat_min = 2; lat_max = 2; done9 = 0;
    for (int i = 0; i < MAX_PENDING; i++) begin
      issue(1, 1'b1, 24'h000300 + 24'(4 * i), 32'h0, 50, ok); chk("full_rd_ok", ok, 1);
    end
    fork
      begin issue(1, 1'b1, 24'h000400, 32'h0, 300, ok9); done9 = 1; end
    join_none
    issue(0, 1'b0, 24'h000500, 32'h1234_5678, 20, ok);
    chk("full_write_ok", ok, 1);
    repeat (10) @(negedge clk);
    chk("full_rd_stalled", {done9, m1_waitrequest}, 2'b01);
    @(posedge clk); #1;
    hold_returns = 0;
    wait fork;
    chk("full_rd_unblocked", ok9, 1);
    drain("full_drain");

    // ---- 10-cycle controller stall during OWN1 ----
    force_wait = 1; s = cyc;
    fork
      issue(1, 1'b0, 24'h05A5A5, 32'hCAFE_F00D, 100, ok5);
    join_none
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i >= 1)
        chk("stall_hold", {sd_write, sd_read, m0_waitrequest, m1_waitrequest, sd_address, sd_writedata},
            {1'b1, 1'b0, 1'b1, 1'b1, 24'h05A5A5, 32'hCAFE_F00D});
    end
    @(posedge clk); #1;
    force_wait = 0;
    wait fork;
    chk("stall_ok", ok5, 1);
    chk("stall_accept_cycle", (acc_cyc_q.size() > 0) ? acc_cyc_q[$] - s : -1, 11);

    // ---- reset asserted mid-OWN0 ----
    force_wait = 1;
    fork
      issue(0, 1'b1, 24'h000077, 32'h0, 3, okr);
    join_none
    @(negedge clk);
    @(negedge clk);
    chk("own0_before_reset", sd_read, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_async_rw", {sd_read, sd_write}, 0);
    chk("reset_async_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);
    wait fork;
    chk("reset_no_accept", okr, 0);
    force_wait = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    acc_port_q.delete(); acc_cyc_q.delete();
    fork
      issue(0, 1'b0, 24'h000600, 32'h6, 50, ok);
      issue(1, 1'b0, 24'h000700, 32'h7, 50, ok5);
    join
    chk("first_grant_port0", (acc_port_q.size() > 0) ? acc_port_q[0] : -1, 0);

    // ---- randomized traffic ----
    rnd_wait_en = 1; lat_min = 1; lat_max = 10;
    fork
      for (int i = 0; i < 40; i++) begin
        n = $urandom_range(0, 3);
        if (n > 0) begin repeat (n) @(posedge clk); #1; end
        issue(0, 1'($urandom_range(0, 1)), 24'($urandom), $urandom, 500, ok);
        chk("rand_ok0", ok, 1);
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
        issue(1, 1'($urandom_range(0, 1)), 24'($urandom), $urandom, 500, ok5);
        chk("rand_ok1", ok5, 1);
      end
    join
    rnd_wait_en = 0;
    drain("rand_drain");

    // ---- orphan return ----
    chk("orphan_pre", err_orphan, 0);
    orphan_req++;
    repeat (4) begin @(posedge clk); #1; end
    chk("orphan_set", err_orphan, 1);
    repeat (5) begin @(posedge clk); #1; end
    chk("orphan_sticky", err_orphan, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
